// File: rtl/bit_serializer_pkg.sv
//------------------------------------------------------------------------------
// bit_serializer_pkg
// Shared state encoding for the parallel-to-serial converter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bit_serializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

endpackage : bit_serializer_pkg

`default_nettype wire

// File: rtl/bit_serializer.sv
//------------------------------------------------------------------------------
// bit_serializer
// Parallel word to serial bit stream, with a one-word hold buffer for gap-free
// back-to-back output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_hold;
  logic [WIDTH-1:0]   w_shift_adv;
  logic [c_CNT_W-1:0] r_count;
  logic               r_hold_full;
  logic               w_xfer;
  logic               w_at_last;
  logic               w_emit;

  assign w_xfer    = din_valid & ~r_hold_full;
  assign w_at_last = (r_count == c_LAST);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_emit      = r_shift[WIDTH-1];
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_emit      = r_shift[0];
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_at_last && !r_hold_full && !w_xfer) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A word arriving mid-shift parks in r_hold; on the last bit the held word
  // takes priority, otherwise a word offered on that same edge loads directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_count     <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_shift <= din;
            r_count <= '0;
          end
        end
        ST_SHIFT: begin
          if (!w_at_last) begin
            r_shift <= w_shift_adv;
            r_count <= r_count + c_CNT_W'(1);
            if (w_xfer) begin
              r_hold      <= din;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            r_shift     <= r_hold;
            r_count     <= '0;
            r_hold_full <= 1'b0;
          end else if (w_xfer) begin
            r_shift <= din;
            r_count <= '0;
          end else begin
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    din_ready = ~r_hold_full;
    out       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (r_state == ST_SHIFT) begin
      out       = w_emit;
      out_valid = 1'b1;
      out_last  = w_at_last;
    end
  end

endmodule : bit_serializer

`default_nettype wire

// File: tb/tb_bit_serializer.sv
//------------------------------------------------------------------------------
// tb_bit_serializer
// Self-checking bench: word-queue reference model plus directed scenarios.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main DUT: WIDTH=8, MSB first
  logic       rst_a = 1'b1;
  logic [7:0] din_a = '0;
  logic       vld_a = 1'b0;
  logic       rdy_a, out_a, ov_a, ol_a;

  // WIDTH=8, LSB first; WIDTH=6 feeding the detector
  logic       rst_bc = 1'b1;
  logic [7:0] din_b  = '0;
  logic       vld_b  = 1'b0;
  logic       rdy_b, out_b, ov_b, ol_b;
  logic [5:0] din_c  = '0;
  logic       vld_c  = 1'b0;
  logic       rdy_c, out_c, ov_c, ol_c;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(rst_a), .din(din_a), .din_valid(vld_a),
    .din_ready(rdy_a), .out(out_a), .out_valid(ov_a), .out_last(ol_a));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(rst_bc), .din(din_b), .din_valid(vld_b),
    .din_ready(rdy_b), .out(out_b), .out_valid(ov_b), .out_last(ol_b));

  bit_serializer #(.WIDTH(6), .MSB_FIRST(1'b1)) u_w6 (
    .clk(clk), .reset(rst_bc), .din(din_c), .din_valid(vld_c),
    .din_ready(rdy_c), .out(out_c), .out_valid(ov_c), .out_last(ol_c));

  // Reference model: current word with bits remaining, plus a queue of
  // accepted words not yet started. Ready whenever nothing is waiting.
  logic [7:0] m_cur = '0;
  int         m_rem = 0;
  logic [7:0] m_pend[$];
  bit         m_acc = 1'b0;

  always @(posedge clk) begin
    bit direct;
    direct = 1'b0;
    if (rst_a) begin
      m_cur = '0;
      m_rem = 0;
      m_pend.delete();
      m_acc = 1'b0;
    end else begin
      m_acc = vld_a && (m_pend.size() == 0);
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if (m_pend.size() > 0) begin
        m_cur = m_pend.pop_front();
        m_rem = 8;
      end else if (m_acc) begin
        m_cur  = din_a;
        m_rem  = 8;
        direct = 1'b1;
      end else begin
        m_rem = 0;
      end
      if (m_acc && !direct) m_pend.push_back(din_a);
    end
  end

  // {out, out_valid, out_last, din_ready}
  function automatic logic [3:0] m_exp();
    logic b;
    b = 1'b0;
    if (m_rem > 0) b = m_cur[m_rem-1];
    return {b, (m_rem > 0), (m_rem == 1), (m_pend.size() == 0)};
  endfunction

  // Downstream pattern detector on the WIDTH=6 stream
  logic [5:0] det_sh;
  logic       det;
  always @(posedge clk) begin
    if (rst_bc) begin
      det_sh <= '0;
      det    <= 1'b0;
    end else begin
      if (ov_c) det_sh <= {det_sh[4:0], out_c};
      det <= ov_c && ol_c && ({det_sh[4:0], out_c} == 6'b110011);
    end
  end

  task automatic test_reset();
    rst_a = 1'b1; rst_bc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_bc = 1'b0;
    n_checks++;
    if ({out_a, ov_a, ol_a, rdy_a} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_msb: got %b expected 0001", {out_a, ov_a, ol_a, rdy_a});
    end
    n_checks++;
    if ({out_b, ov_b, ol_b, rdy_b, out_c, ov_c, ol_c, rdy_c} !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL reset_others: got %b expected 00010001",
               {out_b, ov_b, ol_b, rdy_b, out_c, ov_c, ol_c, rdy_c});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [3:0] exp_v;
    w = 8'hA5;
    din_a = w; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0; din_a = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      exp_v = (k < 8) ? {w[7-k], 1'b1, (k == 7), 1'b1} : 4'b0001;
      n_checks++;
      if ({out_a, ov_a, ol_a, rdy_a} !== exp_v) begin
        n_fail++;
        $display("FAIL single_A5 cyc %0d: got %b expected %b", k, {out_a, ov_a, ol_a, rdy_a}, exp_v);
      end
      n_checks++;
      if ({out_a, ov_a, ol_a, rdy_a} !== m_exp()) begin
        n_fail++;
        $display("FAIL single_model cyc %0d: got %b expected %b", k, {out_a, ov_a, ol_a, rdy_a}, m_exp());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3];
    int idx, vcnt, first, lastc;
    words = '{8'hF0, 8'h0F, 8'hAA};
    idx = 0; vcnt = 0; first = -1; lastc = -1;
    din_a = words[0]; vld_a = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      if (vld_a && m_acc) begin
        idx++;
        if (idx < 3) din_a = words[idx];
        else vld_a = 1'b0;
      end
      n_checks++;
      if ({out_a, ov_a, ol_a, rdy_a} !== m_exp()) begin
        n_fail++;
        $display("FAIL b2b_model cyc %0d: got %b expected %b", cyc, {out_a, ov_a, ol_a, rdy_a}, m_exp());
      end
      if (ov_a) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        vcnt++;
      end
    end
    n_checks++;
    if (vcnt != 24 || (lastc - first) != 23) begin
      n_fail++;
      $display("FAIL b2b_gapfree: got %0d valid cycles over span %0d expected 24 over 23",
               vcnt, lastc - first);
    end
  endtask

  task automatic test_hold_ignore();
    logic [15:0] got;
    int vcnt;
    got = '0; vcnt = 0;
    @(negedge clk);
    din_a = 8'h3C; vld_a = 1'b1;
    @(negedge clk);
    din_a = 8'hC3;
    @(negedge clk);
    din_a = 8'h81;
    @(negedge clk);
    vld_a = 1'b0; din_a = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      n_checks++;
      if ({out_a, ov_a, ol_a, rdy_a} !== m_exp()) begin
        n_fail++;
        $display("FAIL hold_model cyc %0d: got %b expected %b", cyc, {out_a, ov_a, ol_a, rdy_a}, m_exp());
      end
      if (ov_a) vcnt++;
      @(negedge clk);
    end
    // The 3C word started before the loop; 14 of its+C3's bits remain.
    n_checks++;
    if (vcnt != 14) begin
      n_fail++;
      $display("FAIL hold_ignore_count: got %0d bits expected 14", vcnt);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    din_a = 8'hFF; vld_a = 1'b1;
    @(negedge clk);
    din_a = 8'h3C;
    @(negedge clk);
    vld_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_checks++;
    if ({out_a, ov_a, ol_a, rdy_a} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid: got %b expected 0001", {out_a, ov_a, ol_a, rdy_a});
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (ov_a !== 1'b0 || {out_a, ov_a, ol_a, rdy_a} !== m_exp()) begin
        n_fail++;
        $display("FAIL reset_mid_drop cyc %0d: got %b expected %b", cyc, {out_a, ov_a, ol_a, rdy_a}, m_exp());
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({out_a, ov_a, ol_a, rdy_a} !== m_exp()) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got %b expected %b", cyc, {out_a, ov_a, ol_a, rdy_a}, m_exp());
      end
      if (cyc >= 400) begin
        vld_a = 1'b0;
      end else if (!vld_a || m_acc) begin
        vld_a = ($urandom_range(0, 3) != 0);
        din_a = 8'($urandom);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words[2];
    logic [7:0] w;
    words = '{8'hA5, 8'h01};
    for (int i = 0; i < 2; i++) begin
      w = words[i];
      @(negedge clk);
      din_b = w; vld_b = 1'b1;
      @(negedge clk);
      vld_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if ({out_b, ov_b, ol_b} !== {w[k], 1'b1, (k == 7)}) begin
          n_fail++;
          $display("FAIL lsb_%02h bit %0d: got %b expected %b", w, k, {out_b, ov_b, ol_b}, {w[k], 1'b1, (k == 7)});
        end
        @(negedge clk);
      end
      n_checks++;
      if (ov_b !== 1'b0) begin
        n_fail++;
        $display("FAIL lsb_%02h_end: got out_valid %b expected 0", w, ov_b);
      end
    end
  endtask

  task automatic test_pattern_w6();
    logic [5:0] pats[2];
    logic [5:0] p;
    logic       exp_det;
    pats = '{6'b110011, 6'b110010};
    for (int i = 0; i < 2; i++) begin
      p = pats[i];
      @(negedge clk);
      din_c = p; vld_c = 1'b1;
      @(negedge clk);
      vld_c = 1'b0;
      for (int k = 0; k < 9; k++) begin
        if (k < 6) begin
          n_checks++;
          if ({out_c, ov_c, ol_c} !== {p[5-k], 1'b1, (k == 5)}) begin
            n_fail++;
            $display("FAIL w6_%b bit %0d: got %b expected %b", p, k, {out_c, ov_c, ol_c}, {p[5-k], 1'b1, (k == 5)});
          end
        end
        exp_det = (k == 6) && (i == 0);
        n_checks++;
        if (det !== exp_det) begin
          n_fail++;
          $display("FAIL w6_detect_%b cyc %0d: got %b expected %b", p, k, det, exp_det);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_hold_ignore();
    test_reset_mid_shift();
    test_random();
    test_lsb_first();
    test_pattern_w6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bit_serializer

`default_nettype wire
